vga_fb_arbiter: RTL and testbench
=================================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 The block SHALL accept parameter ADDR_W, default 19, giving the framebuffer address width.
REQ-002 The block SHALL accept parameter DATA_W, default 12, giving the pixel word width.
REQ-003 The block SHALL accept parameter STARVE_LIMIT, default 1024, giving the writer wait-cycle count that flags starvation (1..65535).
REQ-004 The block SHALL use the following ports:
  i_clk  in  1  clock; all state on rising edge
  i_rstn  in  1  reset, asynchronous, active-low
  i_disp_req  in  1  display scanout read request; never back-pressured
  i_disp_addr  in  ADDR_W  display read address
  o_disp_rdata  out  DATA_W  display read data
  o_disp_rvalid  out  1  o_disp_rdata valid this cycle
  i_w0_valid / i_w1_valid  in  1  writer 0/1 write request
  i_w0_addr / i_w1_addr  in  ADDR_W  writer 0/1 address
  i_w0_data / i_w1_data  in  DATA_W  writer 0/1 data
  o_w0_ready / o_w1_ready  out  1  writer 0/1 write accepted this cycle
  o_mem_en  out  1  memory access strobe
  o_mem_we  out  1  memory write enable
  o_mem_addr  out  ADDR_W  memory address
  o_mem_wdata  out  DATA_W  memory write data
  i_mem_rdata  in  DATA_W  memory read data, 1-cycle read latency
  i_clr_starve  in  1  synchronous clear of starvation flags
  o_w0_starve / o_w1_starve  out  1  sticky starvation flags

Function
REQ-005 The block SHALL share one single-port framebuffer between the display reader and two writers, issuing at most one access per cycle.
REQ-006 Arbitration SHALL be combinational within the cycle; memory outputs and ready signals SHALL depend only on current inputs and the registered round-robin pointer.
REQ-007 i_disp_req high SHALL grant the display with absolute priority: o_mem_en=1, o_mem_we=0, o_mem_addr=i_disp_addr, o_w0_ready=o_w1_ready=0.
REQ-008 i_disp_req low with exactly one writer valid SHALL grant that writer: o_mem_en=1, o_mem_we=1, address/data from that writer, its ready=1.
REQ-009 i_disp_req low with both writers valid SHALL grant the writer selected by round-robin pointer rr (rr=0 -> w0, rr=1 -> w1); the other's ready=0.
REQ-010 On any writer grant, rr SHALL update next edge to point to the other writer; rr SHALL hold otherwise.
REQ-011 With no grant, o_mem_en=0 and o_mem_we=0; o_mem_addr and o_mem_wdata are don't-care.
REQ-012 A write is transferred only in a cycle where valid and ready are both high; a writer SHALL hold addr/data stable while valid and not ready.
REQ-013 o_disp_rvalid SHALL be a registered copy of the display grant, high exactly one cycle after each display request cycle; o_disp_rdata SHALL equal i_mem_rdata.
REQ-014 Back-to-back display requests SHALL produce back-to-back o_disp_rvalid with no bubble, in request order.
REQ-015 A write granted in cycle N followed by a display read of the same address in cycle N+1 SHALL return the new data (memory write-first ordering; no bypass in the block).
REQ-016 Per writer, a 16-bit wait counter SHALL increment each cycle with valid=1 and ready=0, saturate at 65535, and clear to 0 on grant or when valid=0.
REQ-017 o_wN_starve SHALL set on the edge where writer N's wait counter reaches STARVE_LIMIT, and remain set until an edge with i_clr_starve=1.
REQ-018 If starvation set and i_clr_starve coincide on the same edge, set SHALL win.
REQ-019 Starvation SHALL only be reported, never alter grant priority; the display is never delayed.

Reset
REQ-020 While i_rstn=0: rr=0, o_disp_rvalid=0, both wait counters=0, o_w0_starve=o_w1_starve=0; combinational outputs follow inputs per REQ-007..011 with rr=0.
REQ-021 Reset asserted mid-operation SHALL drop a pending o_disp_rvalid immediately; the first cycle after release SHALL arbitrate with rr=0.

Verification
REQ-022 Display req with addr 0x100 for 640 consecutive cycles with w0 valid -> o_mem_we=0 throughout, o_w0_ready=0, o_disp_rvalid high cycles 1..640 with rdata matching memory model.
REQ-023 Both writers valid continuously, i_disp_req=0, after reset -> grants alternate w0,w1,w0,w1; each write lands at correct address.
REQ-024 w0 writes 0xABC to 0x20 in cycle N, display reads 0x20 in N+1 -> o_disp_rdata=0xABC in N+2 with o_disp_rvalid=1.
REQ-025 STARVE_LIMIT=8, w1 valid under continuous display req -> o_w1_starve rises after 8 wait cycles, stays high after req drops; i_clr_starve pulse clears it; pulse coincident with setting edge leaves it set.
REQ-026 Reset asserted the cycle after a display request -> o_disp_rvalid=0 immediately; after release with both writers valid, w0 granted first.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display scanout has absolute priority,
// two writers share the remaining cycles round-robin with starvation flags.
module vga_fb_arbiter #(
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 12,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_disp_req,
    input  logic [ADDR_W-1:0] i_disp_addr,
    output logic [DATA_W-1:0] o_disp_rdata,
    output logic              o_disp_rvalid,
    input  logic              i_w0_valid,
    input  logic [ADDR_W-1:0] i_w0_addr,
    input  logic [DATA_W-1:0] i_w0_data,
    output logic              o_w0_ready,
    input  logic              i_w1_valid,
    input  logic [ADDR_W-1:0] i_w1_addr,
    input  logic [DATA_W-1:0] i_w1_data,
    output logic              o_w1_ready,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_clr_starve,
    output logic              o_w0_starve,
    output logic              o_w1_starve
);

    localparam logic [15:0] LIM     = 16'(STARVE_LIMIT);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_DISP,
        GNT_W0,
        GNT_W1
    } gnt_e;

    gnt_e gnt;

    logic rr_q;
    logic rr_d;
    logic rvalid_q;
    logic rvalid_d;

    logic [1:0][15:0] wait_q;
    logic [1:0][15:0] wait_d;
    logic [1:0]       starve_q;
    logic [1:0]       starve_d;
    logic [1:0]       wr_valid;
    logic [1:0]       wr_gnt;
    logic [1:0]       stall;
    logic [1:0]       hit;

    // Grant decision is purely combinational on inputs and rr_q
    always_comb begin
        gnt = GNT_NONE;
        if (i_disp_req) begin
            gnt = GNT_DISP;
        end else if (i_w0_valid && i_w1_valid) begin
            gnt = rr_q ? GNT_W1 : GNT_W0;
        end else if (i_w0_valid) begin
            gnt = GNT_W0;
        end else if (i_w1_valid) begin
            gnt = GNT_W1;
        end
    end

    always_comb begin
        o_mem_en    = (gnt != GNT_NONE);
        o_mem_we    = (gnt == GNT_W0) || (gnt == GNT_W1);
        o_w0_ready  = (gnt == GNT_W0);
        o_w1_ready  = (gnt == GNT_W1);
        o_mem_addr  = i_w0_addr;
        o_mem_wdata = i_w0_data;
        unique case (gnt)
            GNT_DISP: o_mem_addr = i_disp_addr;
            GNT_W1: begin
                o_mem_addr  = i_w1_addr;
                o_mem_wdata = i_w1_data;
            end
            default: begin
                o_mem_addr  = i_w0_addr;
                o_mem_wdata = i_w0_data;
            end
        endcase
    end

    always_comb begin
        rr_d = rr_q;
        if (gnt == GNT_W0) begin
            rr_d = 1'b1;
        end else if (gnt == GNT_W1) begin
            rr_d = 1'b0;
        end
        rvalid_d = (gnt == GNT_DISP);
    end

    assign wr_valid = {i_w1_valid, i_w0_valid};
    assign wr_gnt   = {o_w1_ready, o_w0_ready};

    // Starve flag sets only on the increment that lands on LIM
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stall[i]  = wr_valid[i] & ~wr_gnt[i];
            wait_d[i] = '0;
            hit[i]    = 1'b0;
            if (stall[i]) begin
                if (wait_q[i] != CNT_MAX) begin
                    wait_d[i] = wait_q[i] + 16'd1;
                    hit[i]    = ((wait_q[i] + 16'd1) == LIM);
                end else begin
                    wait_d[i] = CNT_MAX;
                end
            end
            starve_d[i] = hit[i] | (starve_q[i] & ~i_clr_starve);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rr_q     <= 1'b0;
            rvalid_q <= 1'b0;
            wait_q   <= '0;
            starve_q <= '0;
        end else begin
            rr_q     <= rr_d;
            rvalid_q <= rvalid_d;
            wait_q   <= wait_d;
            starve_q <= starve_d;
        end
    end

    assign o_disp_rvalid = rvalid_q;
    assign o_disp_rdata  = i_mem_rdata;
    assign o_w0_starve   = starve_q[0];
    assign o_w1_starve   = starve_q[1];

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomised and directed bench for vga_fb_arbiter against a
// cycle-level behavioural model and an external memory model.
module tb_vga_fb_arbiter;

    localparam int AW  = 10;
    localparam int DW  = 12;
    localparam int LIM = 8;
    localparam int DEPTH = 1 << AW;

    logic          i_clk = 1'b0;
    logic          i_rstn;
    logic          i_disp_req;
    logic [AW-1:0] i_disp_addr;
    logic [DW-1:0] o_disp_rdata;
    logic          o_disp_rvalid;
    logic          i_w0_valid;
    logic [AW-1:0] i_w0_addr;
    logic [DW-1:0] i_w0_data;
    logic          o_w0_ready;
    logic          i_w1_valid;
    logic [AW-1:0] i_w1_addr;
    logic [DW-1:0] i_w1_data;
    logic          o_w1_ready;
    logic          o_mem_en;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [DW-1:0] i_mem_rdata;
    logic          i_clr_starve;
    logic          o_w0_starve;
    logic          o_w1_starve;

    vga_fb_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .STARVE_LIMIT(LIM)
    ) dut (
        .i_clk(i_clk),
        .i_rstn(i_rstn),
        .i_disp_req(i_disp_req),
        .i_disp_addr(i_disp_addr),
        .o_disp_rdata(o_disp_rdata),
        .o_disp_rvalid(o_disp_rvalid),
        .i_w0_valid(i_w0_valid),
        .i_w0_addr(i_w0_addr),
        .i_w0_data(i_w0_data),
        .o_w0_ready(o_w0_ready),
        .i_w1_valid(i_w1_valid),
        .i_w1_addr(i_w1_addr),
        .i_w1_data(i_w1_data),
        .o_w1_ready(o_w1_ready),
        .o_mem_en(o_mem_en),
        .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata),
        .i_clr_starve(i_clr_starve),
        .o_w0_starve(o_w0_starve),
        .o_w1_starve(o_w1_starve)
    );

    always #5 i_clk = ~i_clk;

    // External single-port memory, 1-cycle read latency
    logic [DW-1:0] mem [DEPTH];
    logic          fill;

    function automatic logic [DW-1:0] pat(input int a);
        return DW'(a * 37 + 12'h5A5);
    endfunction

    always @(posedge i_clk) begin
        if (fill) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
        end else if (o_mem_en) begin
            if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
            else i_mem_rdata <= mem[o_mem_addr];
        end
    end

    // Behavioural reference state
    logic [DW-1:0] exp_mem [DEPTH];
    bit            m_rr;
    bit            m_rvalid;
    logic [DW-1:0] m_rdata;
    int            m_cnt [2];
    bit            m_starve [2];

    int n_checks = 0;
    int n_fail   = 0;

    // 0 none, 1 display, 2 writer 0, 3 writer 1
    function automatic int exp_gnt();
        if (i_disp_req) return 1;
        if (i_w0_valid && i_w1_valid) return m_rr ? 3 : 2;
        if (i_w0_valid) return 2;
        if (i_w1_valid) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        m_rr = 0;
        m_rvalid = 0;
        m_cnt = '{0, 0};
        m_starve = '{0, 0};
    endtask

    task automatic tick();
        int  g;
        bit  v [2];
        bit  waiting;
        int  nw;
        @(posedge i_clk);
        if (i_rstn) begin
            g = exp_gnt();
            v[0] = i_w0_valid;
            v[1] = i_w1_valid;
            if (g == 2) begin
                exp_mem[i_w0_addr] = i_w0_data;
                m_rr = 1;
            end
            if (g == 3) begin
                exp_mem[i_w1_addr] = i_w1_data;
                m_rr = 0;
            end
            m_rvalid = (g == 1);
            if (g == 1) m_rdata = exp_mem[i_disp_addr];
            for (int i = 0; i < 2; i++) begin
                waiting = v[i] && (g != i + 2);
                nw = waiting ? ((m_cnt[i] < 65535) ? m_cnt[i] + 1 : 65535) : 0;
                if (waiting && nw == LIM && nw != m_cnt[i]) m_starve[i] = 1;
                else if (i_clr_starve) m_starve[i] = 0;
                m_cnt[i] = nw;
            end
        end
        @(negedge i_clk);
    endtask

    task automatic drive(input logic d, input logic [AW-1:0] da,
                         input logic v0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d1);
        i_disp_req  = d;
        i_disp_addr = da;
        i_w0_valid  = v0;
        i_w0_addr   = a0;
        i_w0_data   = d0;
        i_w1_valid  = v1;
        i_w1_addr   = a1;
        i_w1_data   = d1;
    endtask

    task automatic test_reset();
        drive(0, 0, 1, 10'h011, 12'h111, 1, 10'h022, 12'h222);
        #1;
        n_checks++;
        if ({o_disp_rvalid, o_w0_starve, o_w1_starve} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_regs: got %b want 000",
                     {o_disp_rvalid, o_w0_starve, o_w1_starve});
        end
        n_checks++;
        if ({o_mem_en, o_mem_we, o_w0_ready, o_w1_ready} !== 4'b1110) begin
            n_fail++;
            $display("FAIL reset_rr0: got %b want 1110",
                     {o_mem_en, o_mem_we, o_w0_ready, o_w1_ready});
        end
        n_checks++;
        if (o_mem_addr !== 10'h011 || o_mem_wdata !== 12'h111) begin
            n_fail++;
            $display("FAIL reset_wr: got %h/%h want 011/111",
                     o_mem_addr, o_mem_wdata);
        end
        drive(1, 10'h055, 1, 10'h011, 12'h111, 0, 0, 0);
        #1;
        n_checks++;
        if ({o_mem_en, o_mem_we, o_w0_ready, o_w1_ready, o_mem_addr}
            !== {4'b1000, 10'h055}) begin
            n_fail++;
            $display("FAIL reset_disp: got %b %h want 1000 055",
                     {o_mem_en, o_mem_we, o_w0_ready, o_w1_ready}, o_mem_addr);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if ({o_mem_en, o_mem_we} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle: got %b want 00", {o_mem_en, o_mem_we});
        end
        i_rstn = 1'b1;
        model_reset();
        @(negedge i_clk);
    endtask

    task automatic test_disp_priority();
        logic [DW-1:0] want = exp_mem[10'h100];
        for (int i = 0; i < 640; i++) begin
            drive(1, 10'h100, 1, 10'h003, 12'h3C3, 0, 0, 0);
            #1;
            n_checks++;
            if ({o_mem_en, o_mem_we, o_w0_ready} !== 3'b100
                || o_mem_addr !== 10'h100) begin
                n_fail++;
                $display("FAIL disp_prio[%0d]: got %b %h want 100 100", i,
                         {o_mem_en, o_mem_we, o_w0_ready}, o_mem_addr);
            end
            n_checks++;
            if (o_disp_rvalid !== (i > 0)
                || (i > 0 && o_disp_rdata !== want)) begin
                n_fail++;
                $display("FAIL disp_rd[%0d]: got %b %h want %b %h", i,
                         o_disp_rvalid, o_disp_rdata, i > 0, want);
            end
            tick();
        end
        drive(0, 0, 1, 10'h003, 12'h3C3, 0, 0, 0);
        #1;
        n_checks++;
        if ({o_disp_rvalid, o_w0_ready} !== 2'b11
            || o_disp_rdata !== want || o_w0_starve !== 1'b1) begin
            n_fail++;
            $display("FAIL disp_last: got %b%b %h s%b want 11 %h s1",
                     o_disp_rvalid, o_w0_ready, o_disp_rdata, o_w0_starve, want);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        i_clr_starve = 1'b1;
        #1;
        n_checks++;
        if (o_disp_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL disp_end: got %b want 0", o_disp_rvalid);
        end
        tick();
        i_clr_starve = 1'b0;
    endtask

    task automatic test_rr_alternate();
        logic [AW-1:0] qa [$];
        logic [DW-1:0] qd [$];
        logic [DW-1:0] d0, d1;
        logic [AW-1:0] a0, a1;
        int k0 = 0;
        int k1 = 0;
        i_rstn = 1'b0;
        #1;
        i_rstn = 1'b1;
        model_reset();
        a0 = 10'h200;
        d0 = DW'($urandom);
        a1 = 10'h300;
        d1 = DW'($urandom);
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 1, a0, d0, 1, a1, d1);
            #1;
            n_checks++;
            if ({o_w0_ready, o_w1_ready} !== {k % 2 == 0, k % 2 == 1}
                || o_mem_we !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_alt[%0d]: got %b%b we%b want %b%b we1", k,
                         o_w0_ready, o_w1_ready, o_mem_we,
                         k % 2 == 0, k % 2 == 1);
            end
            tick();
            if (k % 2 == 0) begin
                qa.push_back(a0);
                qd.push_back(d0);
                k0++;
                a0 = AW'(10'h200 + k0);
                d0 = DW'($urandom);
            end else begin
                qa.push_back(a1);
                qd.push_back(d1);
                k1++;
                a1 = AW'(10'h300 + k1);
                d1 = DW'($urandom);
            end
        end
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) drive(1, qa[k], 0, 0, 0, 0, 0, 0);
            else drive(0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            if (k > 0) begin
                n_checks++;
                if (o_disp_rvalid !== 1'b1 || o_disp_rdata !== qd[k-1]) begin
                    n_fail++;
                    $display("FAIL rr_land[%0d]: got %b %h want 1 %h", k - 1,
                             o_disp_rvalid, o_disp_rdata, qd[k-1]);
                end
            end
            tick();
        end
    endtask

    task automatic test_write_then_read();
        drive(0, 0, 1, 10'h020, 12'hABC, 0, 0, 0);
        #1;
        n_checks++;
        if (o_w0_ready !== 1'b1 || o_mem_addr !== 10'h020) begin
            n_fail++;
            $display("FAIL wtr_wr: got %b %h want 1 020", o_w0_ready, o_mem_addr);
        end
        tick();
        drive(1, 10'h020, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (o_disp_rvalid !== 1'b1 || o_disp_rdata !== 12'hABC) begin
            n_fail++;
            $display("FAIL wtr_rd: got %b %h want 1 abc", o_disp_rvalid, o_disp_rdata);
        end
        tick();
    endtask

    task automatic test_starve();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        i_clr_starve = 1'b1;
        tick();
        i_clr_starve = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            drive(1, AW'(i), 0, 0, 0, 1, 10'h0F0, 12'h0F0);
            #1;
            n_checks++;
            if (o_w1_ready !== 1'b0 || o_mem_we !== 1'b0) begin
                n_fail++;
                $display("FAIL starve_prio[%0d]: got %b%b want 00", i,
                         o_w1_ready, o_mem_we);
            end
            tick();
            n_checks++;
            if (o_w1_starve !== (i >= LIM)) begin
                n_fail++;
                $display("FAIL starve_set[%0d]: got %b want %b", i,
                         o_w1_starve, i >= LIM);
            end
        end
        drive(0, 0, 0, 0, 0, 1, 10'h0F0, 12'h0F0);
        #1;
        n_checks++;
        if (o_w1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_gnt: got %b want 1", o_w1_ready);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        n_checks++;
        if (o_w1_starve !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_sticky: got %b want 1", o_w1_starve);
        end
        i_clr_starve = 1'b1;
        tick();
        i_clr_starve = 1'b0;
        n_checks++;
        if (o_w1_starve !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_clr: got %b want 0", o_w1_starve);
        end
        for (int i = 1; i <= LIM + 1; i++) begin
            drive(1, 0, 0, 0, 0, 1, 10'h0F1, 12'h0F1);
            i_clr_starve = (i >= LIM);
            tick();
            n_checks++;
            if (o_w1_starve !== (i == LIM)) begin
                n_fail++;
                $display("FAIL starve_race[%0d]: got %b want %b", i,
                         o_w1_starve, i == LIM);
            end
        end
        i_clr_starve = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 1, 10'h040, 12'h404, 0, 0, 0);
        tick();
        drive(1, 10'h040, 0, 0, 0, 0, 0, 0);
        tick();
        #1;
        n_checks++;
        if (o_disp_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: got %b want 1", o_disp_rvalid);
        end
        drive(0, 0, 1, 10'h041, 12'h411, 1, 10'h042, 12'h422);
        i_rstn = 1'b0;
        #1;
        n_checks++;
        if (o_disp_rvalid !== 1'b0 || o_w0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_rst: got rv%b r0%b want rv0 r01",
                     o_disp_rvalid, o_w0_ready);
        end
        model_reset();
        i_rstn = 1'b1;
        #1;
        n_checks++;
        if ({o_w0_ready, o_w1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_first: got %b want 10", {o_w0_ready, o_w1_ready});
        end
        tick();
        n_checks++;
        if ({o_w0_ready, o_w1_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_second: got %b want 01", {o_w0_ready, o_w1_ready});
        end
        tick();
    endtask

    task automatic test_random();
        bit hold0 = 0;
        bit hold1 = 0;
        int g;
        for (int k = 0; k < 500; k++) begin
            if (!hold0) begin
                i_w0_valid = ($urandom_range(0, 2) != 0);
                i_w0_addr  = AW'($urandom_range(0, 31));
                i_w0_data  = DW'($urandom);
            end
            if (!hold1) begin
                i_w1_valid = ($urandom_range(0, 2) != 0);
                i_w1_addr  = AW'($urandom_range(0, 31));
                i_w1_data  = DW'($urandom);
            end
            i_disp_req   = ($urandom_range(0, 3) == 0);
            i_disp_addr  = AW'($urandom_range(0, 31));
            i_clr_starve = ($urandom_range(0, 15) == 0);
            #1;
            g = exp_gnt();
            n_checks++;
            if ({o_mem_en, o_mem_we, o_w0_ready, o_w1_ready}
                !== {g != 0, g >= 2, g == 2, g == 3}) begin
                n_fail++;
                $display("FAIL rnd_ctl[%0d]: got %b want gnt %0d", k,
                         {o_mem_en, o_mem_we, o_w0_ready, o_w1_ready}, g);
            end
            n_checks++;
            if ((g == 1 && o_mem_addr !== i_disp_addr)
                || (g == 2 && {o_mem_addr, o_mem_wdata} !== {i_w0_addr, i_w0_data})
                || (g == 3 && {o_mem_addr, o_mem_wdata} !== {i_w1_addr, i_w1_data})) begin
                n_fail++;
                $display("FAIL rnd_bus[%0d]: got %h/%h for gnt %0d", k,
                         o_mem_addr, o_mem_wdata, g);
            end
            n_checks++;
            if (o_disp_rvalid !== m_rvalid
                || (m_rvalid && o_disp_rdata !== m_rdata)) begin
                n_fail++;
                $display("FAIL rnd_rd[%0d]: got %b %h want %b %h", k,
                         o_disp_rvalid, o_disp_rdata, m_rvalid, m_rdata);
            end
            n_checks++;
            if ({o_w0_starve, o_w1_starve} !== {m_starve[0], m_starve[1]}) begin
                n_fail++;
                $display("FAIL rnd_starve[%0d]: got %b%b want %b%b", k,
                         o_w0_starve, o_w1_starve, m_starve[0], m_starve[1]);
            end
            hold0 = i_w0_valid && (g != 2);
            hold1 = i_w1_valid && (g != 3);
            tick();
        end
        i_clr_starve = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rstn       = 1'b0;
        i_clr_starve = 1'b0;
        fill         = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = pat(i);
        model_reset();
        @(negedge i_clk);
        fill = 1'b0;
        @(negedge i_clk);
        test_reset();
        test_disp_priority();
        test_rr_alternate();
        test_write_then_read();
        test_starve();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
